reaction_ctrl: RTL and testbench

- Sequencing controller for the reaction-time detector.
- Drives the 2-digit BCD counter's clear and enable inputs from a prescaled millisecond tick.
- Runs the start → delay → stimulus-LED → measure → stop/foul/timeout flow.
- Sits between the debounced push-buttons and the BCD counter/display path. It reads the counter digits back to detect saturation at 99.

---
 rtl/reaction_pkg.sv | 6 +
 rtl/reaction_tick_gen.sv | 14 +
 rtl/reaction_ctrl.sv | 99 +++++++++
 tb/tb_reaction_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: state encoding, BCD saturation digit and LFSR tap mask shared by the reaction controller
package reaction_pkg;
  typedef enum logic [2:0] {IDLE, DELAY, RUN, DONE, FOUL} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/reaction_tick_gen.sv
// tick_gen: free-running prescaler (in clk, clr; out tick) giving a one-cycle tick every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(TICK_DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= clr ? '0 : cnt_d;
endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-timer sequencer (in clk, clr, start, stop, bcd1, bcd0; out cnt_clr, cnt_en, led, busy, timeout, foul); REACTION_RANDOM_DELAY_EN adds an LFSR-randomised delay
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int         TICK_DIV    = 50000,
  parameter int         DELAY_TICKS = 2000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       led,
  output logic       busy,
  output logic       timeout,
  output logic       foul
);
  localparam int DW = $clog2(2 * DELAY_TICKS + 1);
  state_t state_q, state_d;
  logic [DW-1:0] dly_q, dly_d, dly_load;
  logic start_q, stop_q, led_q, led_d, busy_q, busy_d, timeout_q, timeout_d, foul_q, foul_d;
  logic tick, start_rise, stop_rise, go, at_max;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .clr(clr), .tick(tick));
`ifdef REACTION_RANDOM_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  assign dly_load = DW'(DELAY_TICKS + (int'(lfsr_q) * DELAY_TICKS) / 256);
  always_ff @(posedge clk) lfsr_q <= clr ? LFSR_SEED : lfsr_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, LFSR_TAPS};
  assign dly_load = DW'(DELAY_TICKS);
`endif
  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign at_max     = bcd1 == BCD_NINE && bcd0 == BCD_NINE;
  // start only re-arms from the idle-like states, so it wins over stop there and is ignored in DELAY/RUN
  assign go         = start_rise && (state_q == IDLE || state_q == DONE || state_q == FOUL);
  assign cnt_clr    = clr | go;
  // saturate at 99 instead of wrapping; stop suppresses a coincident tick
  assign cnt_en     = ~clr & (state_q == RUN) & tick & ~stop_rise & ~at_max;
  assign led        = led_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign foul       = foul_q;
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    timeout_d = timeout_q;
    foul_d    = foul_q;
    if (go) begin
      state_d   = DELAY;
      dly_d     = dly_load;
      timeout_d = 1'b0;
      foul_d    = 1'b0;
    end else if (state_q == DELAY) begin
      if (stop_rise) begin
        state_d = FOUL;
        foul_d  = 1'b1;
      end else if (tick) begin
        dly_d   = dly_q - 1'b1;
        state_d = dly_q == DW'(1) ? RUN : DELAY;
      end
    end else if (state_q == RUN) begin
      if (stop_rise) state_d = DONE;
      else if (tick && at_max) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
    end
    led_d  = state_d == RUN;
    busy_d = state_d == DELAY || state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      foul_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      start_q   <= start;
      stop_q    <= stop;
      led_q     <= led_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      foul_q    <= foul_d;
    end
  end
endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: directed and random stimulus checked against a behavioural reaction-timer model with its own BCD counter
module tb_reaction_ctrl;
  localparam int TD = 4;
  localparam int DT = 3;
  logic clk = 1'b0;
  logic clr = 1'b1, start = 1'b0, stop = 1'b0;
  logic [3:0] bcd1 = 4'd0, bcd0 = 4'd0;
  logic cnt_clr, cnt_en, led, busy, timeout, foul;
  int total = 0, fails = 0;
  typedef enum {M_IDLE, M_WAIT, M_MEAS, M_HELD, M_FOULED} mph_t;
  mph_t ph = M_IDLE;
  int pre = 0, left = 0, count = 0;
  logic ps = 1'b0, pt = 1'b0, e_led = 1'b0, e_busy = 1'b0, e_to = 1'b0, e_foul = 1'b0;
  always #5 clk = ~clk;
  reaction_ctrl #(.TICK_DIV(TD), .DELAY_TICKS(DT), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .bcd1(bcd1), .bcd0(bcd0),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .led(led), .busy(busy), .timeout(timeout), .foul(foul)
  );
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_step(input logic c, input logic s, input logic t, output logic ec, output logic ee);
    logic tk, sr, tr;
    tk = pre == TD - 1;
    sr = s && !ps;
    tr = t && !pt;
    ec = c;
    ee = 1'b0;
    if (c) begin
      ph = M_IDLE; pre = 0; ps = 0; pt = 0; count = 0;
      e_led = 0; e_busy = 0; e_to = 0; e_foul = 0;
    end else begin
      pre = tk ? 0 : pre + 1;
      if ((ph == M_IDLE || ph == M_HELD || ph == M_FOULED) && sr) begin
        ec = 1; ph = M_WAIT; left = DT; e_to = 0; e_foul = 0;
      end else if (ph == M_WAIT) begin
        if (tr) begin ph = M_FOULED; e_foul = 1; end
        else if (tk) begin left--; if (left == 0) ph = M_MEAS; end
      end else if (ph == M_MEAS) begin
        if (tr) ph = M_HELD;
        else if (tk && count == 99) begin ph = M_HELD; e_to = 1; end
        else if (tk) ee = 1;
      end
      ps = s; pt = t;
      if (ec) count = 0; else if (ee) count++;
      e_led = ph == M_MEAS;
      e_busy = ph == M_WAIT || ph == M_MEAS;
    end
  endtask
  task automatic cycle(input logic c, input logic s, input logic t);
    logic ec, ee;
    clr = c; start = s; stop = t;
    bcd1 = 4'(count / 10);
    bcd0 = 4'(count % 10);
    #1;
    chk("led", led, e_led);
    chk("busy", busy, e_busy);
    chk("timeout", timeout, e_to);
    chk("foul", foul, e_foul);
    model_step(c, s, t, ec, ee);
    chk("cnt_clr", cnt_clr, ec);
    chk("cnt_en", cnt_en, ee);
    @(negedge clk);
  endtask
  task automatic go_run();
    cycle(0, 1, 0);
    for (int i = 0; i < 100 && ph != M_MEAS; i++) cycle(0, 0, 0);
    chk("reach_run", ph == M_MEAS, 1'b1);
  endtask
  initial begin
    @(negedge clk);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("idle_led", led, 1'b0);
    chk("idle_busy", busy, 1'b0);
    go_run();
    for (int i = 0; i < 500 && !e_to; i++) cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("to_set", timeout, 1'b1);
    chk("to_led", led, 1'b0);
    chk("to_hold99", count == 99, 1'b1);
    go_run();
    for (int i = 0; i < 100 && !(ph == M_MEAS && count == 4 && pre == TD - 1); i++) cycle(0, 0, 0);
    chk("sync_5th_tick", count == 4 && pre == TD - 1, 1'b1);
    cycle(0, 0, 1);
    chk("stop_led", led, 1'b0);
    chk("stop_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("stop_hold04", count == 4, 1'b1);
    cycle(0, 1, 0);
    for (int i = 0; i < 100 && !(ph == M_WAIT && left == DT - 1); i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("foul_set", foul, 1'b1);
    for (int i = 0; i < 30; i++) cycle(0, 0, i < 10);
    chk("foul_no_led", led, 1'b0);
    cycle(0, 1, 0);
    chk("foul_cleared", foul, 1'b0);
    cycle(0, 0, 0);
    for (int i = 0; i < 100 && ph != M_MEAS; i++) cycle(0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);
    cycle(0, 1, 1);
    chk("held_stop_new_delay", busy, 1'b1);
    chk("held_stop_no_foul", foul, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    chk("simul_idle_busy", busy, 1'b1);
    chk("simul_idle_foul", foul, 1'b0);
    cycle(0, 0, 0);
    go_run();
    for (int i = 0; i < 9; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("midclr_led", led, 1'b0);
    chk("midclr_busy", busy, 1'b0);
    chk("midclr_to", timeout, 1'b0);
    chk("midclr_foul", foul, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      logic c, s, t;
      c = $urandom_range(0, 399) == 0;
      s = $urandom_range(0, 29) == 0 ? ~start : start;
      t = $urandom_range(0, 39) == 0 ? ~stop : stop;
      cycle(c, s, t);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
